// File: rtl/b_resp_fifo_if.sv
// rtl/b_resp_fifo_if.sv - AXI B-channel handshake bundle for b_resp_fifo.
interface b_resp_fifo_if #(
   parameter int ID_WIDTH = 4
);
   logic [ID_WIDTH-1:0] BID;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   modport master (output BID, output BRESP, output BVALID, input BREADY);
   modport slave  (input BID, input BRESP, input BVALID, output BREADY);
endinterface

// File: rtl/b_resp_fifo.sv
// rtl/b_resp_fifo.sv - in-order AXI write-response buffer with count/almost-full flags.
// Optional macro B_RESP_FIFO_BYPASS_EN: same-cycle pass-through when empty.
module b_resp_fifo #(
   parameter int DEPTH    = 4,
   parameter int ID_WIDTH = 4,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   b_resp_fifo_if.slave            s,
   b_resp_fifo_if.master           m,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ID_WIDTH + 2;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [EW-1:0] head;
   logic          push;
   logic          pop;
   logic          push_store;
   logic          pop_store;

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CW'(AF_LEVEL));

   assign head     = mem[rd_ptr];
   assign s.BREADY = ~full;
   assign push     = s.BVALID & s.BREADY;
   assign pop      = m.BVALID & m.BREADY;

`ifdef B_RESP_FIFO_BYPASS_EN
   logic bypass;
   // A response arriving at an empty buffer is presented directly; it is
   // only stored if the consumer does not take it this cycle.
   assign bypass     = empty & s.BVALID;
   assign m.BVALID   = ~empty | s.BVALID;
   assign m.BID      = bypass ? s.BID   : head[EW-1:2];
   assign m.BRESP    = bypass ? s.BRESP : head[1:0];
   assign push_store = push & ~(bypass & m.BREADY);
   assign pop_store  = pop & ~empty;
`else
   assign m.BVALID   = ~empty;
   assign m.BID      = head[EW-1:2];
   assign m.BRESP    = head[1:0];
   assign push_store = push;
   assign pop_store  = pop;
`endif

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_store) begin
            mem[wr_ptr] <= {s.BID, s.BRESP};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_store) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_store, pop_store})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_b_resp_fifo.sv
// tb/tb_b_resp_fifo.sv - directed self-checking bench for b_resp_fifo (DEPTH=4, AF_LEVEL=3).
module tb_b_resp_fifo;
   logic       ACLK = 1'b0;
   logic       ARESETn;
   logic [2:0] count;
   logic       full, empty, almost_full;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] nid;

   b_resp_fifo_if #(.ID_WIDTH(4)) s_if ();
   b_resp_fifo_if #(.ID_WIDTH(4)) m_if ();

   b_resp_fifo #(.DEPTH(4), .ID_WIDTH(4), .AF_LEVEL(3)) dut (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .s           (s_if),
      .m           (m_if),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] id, input logic [1:0] r, input logic rdy);
      s_if.BVALID = v;
      s_if.BID    = id;
      s_if.BRESP  = r;
      m_if.BREADY = rdy;
      #1;
   endtask

   initial begin
      ARESETn = 1'b0;
      drive(1'b0, 4'd0, 2'd0, 1'b0);
      step();
      step();
      ARESETn = 1'b1;
      repeat (3) step();

      // 1: reset state
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_sready", s_if.BREADY, 1);
      chk("rst_mvalid", m_if.BVALID, 0);
      chk("rst_mbid", m_if.BID, 0);
      chk("rst_af", almost_full, 0);

      // 2: fill to full with the consumer stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i + 1), 2'(i), 1'b0);
         chk("fill_sready", s_if.BREADY, 1);
         step();
         chk("fill_count", count, i + 1);
         chk("fill_af", almost_full, (i + 1 >= 3));
         chk("fill_full", full, (i == 3));
         chk("fill_mvalid", m_if.BVALID, 1);
         chk("fill_head", m_if.BID, 1);
      end
      drive(1'b1, 4'd5, 2'd1, 1'b0);
      chk("full_sready", s_if.BREADY, 0);
      step();
      chk("full_reject_count", count, 4);
      chk("full_reject_head", m_if.BID, 1);

      // drain; ID 5 still offered during the first pop cycle, rejected by full
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b1, 4'd5, 2'd1, 1'b1);
         else        drive(1'b0, 4'd5, 2'd1, 1'b1);
         chk("drain_mvalid", m_if.BVALID, 1);
         chk("drain_bid", m_if.BID, i + 1);
         chk("drain_bresp", m_if.BRESP, i);
         step();
         chk("drain_count", count, 3 - i);
         if (i == 0) chk("drain_sready_back", s_if.BREADY, 1);
      end
      chk("drain_empty", empty, 1);
      drive(1'b1, 4'd5, 2'd1, 1'b0);
      step();
      chk("id5_count", count, 1);
      chk("id5_bid", m_if.BID, 5);
      chk("id5_bresp", m_if.BRESP, 1);
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      step();
      chk("id5_pop_empty", empty, 1);

      // 3: wrap-around, 10 rounds of push 3 / pop 3
      nid = 4'd0;
      for (int r = 0; r < 10; r++) begin
         for (int j = 0; j < 3; j++) begin
            drive(1'b1, nid + 4'(j), 2'(nid + 4'(j)), 1'b0);
            step();
         end
         chk("wrap_count3", count, 3);
         for (int j = 0; j < 3; j++) begin
            drive(1'b0, 4'd0, 2'd0, 1'b1);
            chk("wrap_bid", m_if.BID, 4'(nid + 4'(j)));
            chk("wrap_bresp", m_if.BRESP, 2'(nid + 4'(j)));
            step();
         end
         chk("wrap_count0", count, 0);
         nid = nid + 4'd3;
      end

      // 4: simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i + 1), 2'(i + 1), 1'b0);
         step();
      end
      chk("sim_full", full, 1);
      drive(1'b1, 4'hE, 2'd2, 1'b1);
      step();
      chk("sim_full_count", count, 3);
      chk("sim_full_head", m_if.BID, 2);
      chk("sim_full_sready", s_if.BREADY, 1);
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      step();
      chk("sim_c2_count", count, 2);
      chk("sim_c2_head", m_if.BID, 3);
      drive(1'b1, 4'hF, 2'd3, 1'b1);
      step();
      chk("sim_both_count", count, 2);
      chk("sim_both_head", m_if.BID, 4);
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      step();
      chk("sim_c1_head", m_if.BID, 4'hF);
      chk("sim_c1_bresp", m_if.BRESP, 3);
      chk("sim_c1_count", count, 1);
      drive(1'b1, 4'hA, 2'd2, 1'b1);
      step();
      chk("sim_c1both_count", count, 1);
      chk("sim_c1both_mvalid", m_if.BVALID, 1);
      chk("sim_c1both_bid", m_if.BID, 4'hA);
      chk("sim_c1both_bresp", m_if.BRESP, 2);
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      step();
      chk("sim_end_empty", empty, 1);

      // 5: reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), 2'd0, 1'b0);
         step();
      end
      chk("mid_count3", count, 3);
      ARESETn = 1'b0;
      drive(1'b1, 4'd6, 2'd1, 1'b1);
      step();
      ARESETn = 1'b1;
      drive(1'b0, 4'd0, 2'd0, 1'b0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_mvalid", m_if.BVALID, 0);
      chk("mid_rst_bid", m_if.BID, 0);
      drive(1'b1, 4'd7, 2'd2, 1'b0);
      step();
      drive(1'b0, 4'd0, 2'd0, 1'b0);
      chk("post_rst_mvalid", m_if.BVALID, 1);
      chk("post_rst_bid", m_if.BID, 7);
      chk("post_rst_bresp", m_if.BRESP, 2);
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      step();
      chk("post_rst_empty", empty, 1);

      // 6: empty with s_BVALID and m_BREADY together
      drive(1'b1, 4'd9, 2'd1, 1'b1);
`ifdef B_RESP_FIFO_BYPASS_EN
      chk("byp_mvalid", m_if.BVALID, 1);
      chk("byp_bid", m_if.BID, 9);
      chk("byp_bresp", m_if.BRESP, 1);
      step();
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      chk("byp_count", count, 0);
      chk("byp_empty", empty, 1);
`else
      chk("nobyp_mvalid0", m_if.BVALID, 0);
      step();
      drive(1'b0, 4'd0, 2'd0, 1'b1);
      chk("nobyp_count1", count, 1);
      chk("nobyp_mvalid1", m_if.BVALID, 1);
      chk("nobyp_bid", m_if.BID, 9);
      step();
      chk("nobyp_count0", count, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
